// File: rtl/jugador_control.sv
// Player movement control: button sync/debounce, frame tick, speed ramp FSM,
// clamped sprite position that only changes on the vertical-blanking tick.
module jugador_control #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_LINE       = 480,
  parameter int X_MIN           = 160,
  parameter int X_MAX           = 480,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 480,
  parameter int SPRITE_W        = 60,
  parameter int SPRITE_H        = 60,
  parameter int X_INIT          = 290,
  parameter int Y_INIT          = 400,
  parameter int MAX_STEP        = 4,
  parameter int ACCEL_FRAMES    = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [2:0] speed,
  output logic       frame_tick
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AC_W = $clog2(ACCEL_FRAMES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [AC_W-1:0] AC_LAST = AC_W'(ACCEL_FRAMES);
  localparam logic [AC_W-1:0] AC_ONE  = AC_W'(1);
  localparam logic [2:0]      SPD_MAX = 3'(MAX_STEP);
  localparam logic [9:0]      TICK_V  = 10'(TICK_LINE);

  localparam logic signed [11:0] X_LO = 12'(X_MIN);
  localparam logic signed [11:0] X_HI = 12'(X_MAX - SPRITE_W);
  localparam logic signed [11:0] Y_LO = 12'(Y_MIN);
  localparam logic signed [11:0] Y_HI = 12'(Y_MAX - SPRITE_H);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RAMP   = 2'd1;
  localparam logic [1:0] ST_CRUISE = 2'd2;
  // With a one-pixel top speed the ramp has nothing to do.
  localparam logic [1:0] ST_FIRST  = (MAX_STEP <= 1) ? ST_CRUISE : ST_RAMP;

  // Button order everywhere: {down, up, right, left}
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb;

  assign btn_raw = {btn_down, btn_up, btn_right, btn_left};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic            lvl_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else if (sync2_q[gi] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q <= '0;
          lvl_q <= sync2_q[gi];
        end else begin
          cnt_q <= cnt_q + DB_ONE;
        end
      end

      assign deb[gi] = lvl_q;
    end
  endgenerate

  logic match;
  logic match_q;
  logic frame_tick_q;

  assign match = (hcount == 10'd0) && (vcount == TICK_V);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      match_q      <= match;
      frame_tick_q <= match && !match_q;
    end
  end

  // Direction as one-hot-per-axis flags: {down, up, left, right}; opposing
  // buttons cancel so both flags of an axis are never set together.
  logic [3:0] dir_now;
  assign dir_now = {deb[3] & ~deb[2], deb[2] & ~deb[3],
                    deb[0] & ~deb[1], deb[1] & ~deb[0]};

  logic [1:0]      state_q, state_d;
  logic [2:0]      speed_q, speed_d;
  logic [AC_W-1:0] acc_q, acc_d;
  logic [3:0]      dir_q, dir_d;
  logic [9:0]      posx_q, posx_d;
  logic [9:0]      posy_q, posy_d;

  logic [2:0]         speed_inc;
  logic signed [11:0] step;
  logic signed [11:0] px, py, nx, ny;

  assign speed_inc = speed_q + 3'd1;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    acc_d   = acc_q;
    dir_d   = dir_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    step    = '0;
    px      = $signed({2'b00, posx_q});
    py      = $signed({2'b00, posy_q});
    nx      = px;
    ny      = py;

    if (frame_tick_q) begin
      if (!enable) begin
        state_d = ST_IDLE;
        speed_d = 3'd0;
        acc_d   = '0;
      end else begin
        dir_d = dir_now;
        case (state_q)
          ST_IDLE: begin
            if (dir_now != 4'd0) begin
              state_d = ST_FIRST;
              speed_d = 3'd1;
              acc_d   = AC_ONE;
            end
          end
          ST_RAMP: begin
            if (dir_now == 4'd0) begin
              state_d = ST_IDLE;
              speed_d = 3'd0;
              acc_d   = '0;
            end else if (dir_now != dir_q) begin
              speed_d = 3'd1;
              acc_d   = AC_ONE;
            end else if (acc_q == AC_LAST) begin
              speed_d = speed_inc;
              acc_d   = AC_ONE;
              if (speed_inc == SPD_MAX) state_d = ST_CRUISE;
            end else begin
              acc_d = acc_q + AC_ONE;
            end
          end
          ST_CRUISE: begin
            if (dir_now == 4'd0) begin
              state_d = ST_IDLE;
              speed_d = 3'd0;
              acc_d   = '0;
            end else if (dir_now != dir_q) begin
              state_d = ST_FIRST;
              speed_d = 3'd1;
              acc_d   = AC_ONE;
            end else begin
              speed_d = SPD_MAX;
            end
          end
          default: begin
            state_d = ST_IDLE;
            speed_d = 3'd0;
            acc_d   = '0;
          end
        endcase

        // The move uses the speed chosen on this very tick.
        step = $signed({9'b0, speed_d});
        if (dir_now[0])      nx = px + step;
        else if (dir_now[1]) nx = px - step;
        if (dir_now[3])      ny = py + step;
        else if (dir_now[2]) ny = py - step;

        if (nx < X_LO)      nx = X_LO;
        else if (nx > X_HI) nx = X_HI;
        if (ny < Y_LO)      ny = Y_LO;
        else if (ny > Y_HI) ny = Y_HI;

        posx_d = nx[9:0];
        posy_d = ny[9:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      speed_q <= 3'd0;
      acc_q   <= '0;
      dir_q   <= 4'd0;
      posx_q  <= 10'(X_INIT);
      posy_q  <= 10'(Y_INIT);
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
    end
  end

  assign posx       = posx_q;
  assign posy       = posy_q;
  assign speed      = speed_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_jugador_control.sv
// Directed bench for jugador_control: vector table of button/tick scenarios
// plus hand-written tick, glitch and asynchronous-reset sequences.
module tb_jugador_control;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [9:0] hcount = 10'd5;
  logic [9:0] vcount = 10'd0;
  logic [9:0] posx;
  logic [9:0] posy;
  logic [2:0] speed;
  logic       frame_tick;

  jugador_control #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .hcount     (hcount),
    .vcount     (vcount),
    .posx       (posx),
    .posy       (posy),
    .speed      (speed),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One frame: match seen by exactly one edge, then two edges for the update.
  task automatic do_tick();
    @(negedge clock);
    hcount = 10'd0;
    vcount = 10'd480;
    @(negedge clock);
    hcount = 10'd5;
    vcount = 10'd0;
    @(negedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    int l; int r; int u; int d; int en; int n;
    int ex; int ey; int es;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int l, input int r, input int u, input int d,
                     input int en, input int n,
                     input int ex, input int ey, input int es);
    vec_t v;
    v.l = l; v.r = r; v.u = u; v.d = d; v.en = en; v.n = n;
    v.ex = ex; v.ey = ey; v.es = es;
    vq.push_back(v);
  endtask

  initial begin
    int hits;
    int first_idx;

    //  l  r  u  d en  ticks   x    y   spd
    add(1, 0, 0, 0, 1,  4,   286, 400, 1);  // ramp, speed 1 for 4 ticks
    add(1, 0, 0, 0, 1,  4,   278, 400, 2);
    add(1, 0, 0, 0, 1,  4,   266, 400, 3);
    add(1, 0, 0, 0, 1,  1,   262, 400, 4);  // tick 13: top speed
    add(1, 0, 0, 0, 1,  1,   258, 400, 4);
    add(1, 0, 0, 0, 1, 24,   162, 400, 4);
    add(1, 0, 0, 0, 1,  1,   160, 400, 4);  // left clamp
    add(1, 0, 0, 0, 1,  1,   160, 400, 4);
    add(1, 1, 0, 0, 1,  1,   160, 400, 0);  // conflict cancels -> idle
    add(1, 1, 0, 0, 1,  2,   160, 400, 0);
    add(0, 0, 0, 0, 1,  1,   160, 400, 0);
    add(0, 0, 1, 0, 1,  2,   160, 398, 1);
    add(0, 0, 0, 0, 1,  1,   160, 398, 0);
    add(0, 0, 1, 0, 1, 12,   160, 374, 3);
    add(0, 0, 1, 0, 1, 93,   160,   2, 4);
    add(0, 0, 1, 0, 1,  1,   160,   0, 4);  // top clamp, no wrap
    add(0, 0, 1, 0, 1,  1,   160,   0, 4);
    add(0, 0, 0, 0, 1,  1,   160,   0, 0);
    add(0, 1, 0, 0, 1,  2,   162,   0, 1);
    add(0, 0, 0, 0, 1,  1,   162,   0, 0);
    add(0, 1, 0, 0, 1, 12,   186,   0, 3);
    add(0, 1, 0, 0, 1, 58,   418,   0, 4);
    add(0, 1, 0, 0, 1,  1,   420,   0, 4);  // right clamp
    add(0, 1, 0, 0, 1,  1,   420,   0, 4);
    add(0, 0, 0, 0, 1,  1,   420,   0, 0);
    add(1, 0, 0, 0, 1,  9,   405,   0, 3);
    add(0, 1, 0, 0, 1,  1,   406,   0, 1);  // reversal restarts at 1
    add(0, 0, 0, 0, 1,  1,   406,   0, 0);
    add(0, 0, 0, 1, 1,  5,   406,   6, 2);
    add(0, 0, 0, 1, 0,  1,   406,   6, 0);  // disabled: frozen, speed 0
    add(0, 0, 0, 1, 0,  1,   406,   6, 0);
    add(0, 0, 0, 1, 1,  1,   406,   7, 1);
    add(0, 0, 0, 0, 1,  1,   406,   7, 0);

    // Reset held for three cycles
    settle(3);
    check("reset_posx", int'(posx), 290);
    check("reset_posy", int'(posy), 400);
    check("reset_speed", int'(speed), 0);
    check("reset_tick", int'(frame_tick), 0);
    reset_n = 1'b1;
    settle(2);
    $display("reset: posx=%0d posy=%0d speed=%0d", posx, posy, speed);

    // Match held 10 cycles must give a single one-cycle pulse
    hits = 0;
    first_idx = -1;
    hcount = 10'd0;
    vcount = 10'd480;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (i == 9) begin
        hcount = 10'd5;
        vcount = 10'd0;
      end
      if (frame_tick) begin
        hits++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check("tick_count", hits, 1);
    check("tick_position", first_idx, 0);
    $display("tick: pulses=%0d first_cycle=%0d", hits, first_idx);

    foreach (vq[i]) begin
      btn_left  = (vq[i].l != 0);
      btn_right = (vq[i].r != 0);
      btn_up    = (vq[i].u != 0);
      btn_down  = (vq[i].d != 0);
      enable    = (vq[i].en != 0);
      settle(10);
      repeat (vq[i].n) do_tick();
      check($sformatf("row%0d_posx", i), int'(posx), vq[i].ex);
      check($sformatf("row%0d_posy", i), int'(posy), vq[i].ey);
      check($sformatf("row%0d_speed", i), int'(speed), vq[i].es);
      $display("row %0d: btn l%0d r%0d u%0d d%0d en%0d ticks=%0d -> posx=%0d posy=%0d speed=%0d",
               i, vq[i].l, vq[i].r, vq[i].u, vq[i].d, vq[i].en, vq[i].n,
               posx, posy, speed);
    end

    // 3-cycle glitch on up must never reach the debounced level
    @(negedge clock);
    btn_up = 1'b1;
    settle(3);
    btn_up = 1'b0;
    settle(10);
    do_tick();
    do_tick();
    check("glitch_posy", int'(posy), 7);
    check("glitch_speed", int'(speed), 0);
    $display("glitch: posx=%0d posy=%0d speed=%0d", posx, posy, speed);

    // Asynchronous reset while moving and while frame_tick is high
    btn_right = 1'b1;
    settle(10);
    do_tick();
    do_tick();
    check("premove_posx", int'(posx), 408);
    @(negedge clock);
    hcount = 10'd0;
    vcount = 10'd480;
    @(posedge clock);
    #1;
    check("pre_reset_tick", int'(frame_tick), 1);
    reset_n = 1'b0;
    #1;
    check("async_posx", int'(posx), 290);
    check("async_posy", int'(posy), 400);
    check("async_speed", int'(speed), 0);
    check("async_tick", int'(frame_tick), 0);
    $display("async reset: posx=%0d posy=%0d speed=%0d tick=%0d", posx, posy, speed, frame_tick);
    @(negedge clock);
    hcount = 10'd5;
    vcount = 10'd0;
    btn_right = 1'b0;
    settle(2);
    reset_n = 1'b1;
    settle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
